// File: rtl/bpu_pkg.sv
// Shared types and helpers for the branch prediction unit: BTB entry layout,
// counter reset/allocation values and PC index/tag extraction.
package bpu_pkg;

  localparam int unsigned XLEN_MAX = 32;
  localparam int unsigned TAG_MAX  = XLEN_MAX - 2;
  localparam int unsigned CNT_MAX  = 8;

  // Fields are sized for the widest supported configuration; narrower
  // configurations keep the unused upper bits at zero.
  typedef struct packed {
    logic                valid;
    logic [TAG_MAX-1:0]  tag;
    logic [XLEN_MAX-1:0] target;
    logic [CNT_MAX-1:0]  cnt;
  } bpu_entry_t;

  function automatic logic [CNT_MAX-1:0] cnt_wt(input int unsigned cnt_w);
    return CNT_MAX'(1) << (cnt_w - 1);
  endfunction

  function automatic logic [CNT_MAX-1:0] cnt_wn(input int unsigned cnt_w);
    return cnt_wt(cnt_w) - CNT_MAX'(1);
  endfunction

  function automatic logic [XLEN_MAX-1:0] pc_index(input logic [XLEN_MAX-1:0] pc,
                                                   input int unsigned idx_w);
    return (pc >> 2) & ((XLEN_MAX'(1) << idx_w) - XLEN_MAX'(1));
  endfunction

  function automatic logic [TAG_MAX-1:0] pc_tag(input logic [XLEN_MAX-1:0] pc,
                                                input int unsigned idx_w);
    return TAG_MAX'(pc >> (idx_w + 2));
  endfunction

endpackage

// File: rtl/bpu_if.sv
// Pipeline <-> branch predictor signal bundle (fetch lookup, ID resolve, perf).
interface bpu_if #(
  parameter int unsigned XLEN = 32
);
  logic [XLEN-1:0] if_pc;
  logic            if_pred_taken;
  logic [XLEN-1:0] if_pred_target;
  logic            id_stall;
  logic            id_flush;
  logic            id_valid;
  logic [XLEN-1:0] id_pc;
  logic            id_is_branch;
  logic            id_taken;
  logic [XLEN-1:0] id_target;
  logic            id_redirect;
  logic [XLEN-1:0] id_redirect_pc;
  logic [31:0]     perf_branches;
  logic [31:0]     perf_mispredicts;

  modport master (
    output if_pc, id_stall, id_flush, id_valid, id_pc, id_is_branch, id_taken, id_target,
    input  if_pred_taken, if_pred_target, id_redirect, id_redirect_pc,
           perf_branches, perf_mispredicts
  );

  modport slave (
    input  if_pc, id_stall, id_flush, id_valid, id_pc, id_is_branch, id_taken, id_target,
    output if_pred_taken, if_pred_target, id_redirect, id_redirect_pc,
           perf_branches, perf_mispredicts
  );
endinterface

// File: rtl/bpu_sat_counter.sv
// Next-value logic for an up/down saturating counter.
module sat_counter #(
  parameter int unsigned CNT_W = 2
) (
  input  logic [CNT_W-1:0] i_cnt,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt
);
  always_comb begin
    o_cnt = i_cnt;
    if (i_inc) begin
      if (i_cnt != '1) o_cnt = i_cnt + CNT_W'(1);
    end else begin
      if (i_cnt != '0) o_cnt = i_cnt - CNT_W'(1);
    end
  end
endmodule

// File: rtl/bpu.sv
// Dynamic branch predictor: direct-mapped BTB with saturating counters, same-cycle
// IF lookup, ID-stage mispredict detection and table training.
module bpu
  import bpu_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned CNT_W   = 2
) (
  input logic  clk,
  input logic  rst,
  bpu_if.slave bus
);
  localparam int unsigned       IDX_W = $clog2(ENTRIES);
  localparam logic [CNT_MAX-1:0] WT   = cnt_wt(CNT_W);
  localparam logic [CNT_MAX-1:0] WN   = cnt_wn(CNT_W);

  bpu_entry_t r_tbl [ENTRIES];

  logic            r_c_taken;
  logic [XLEN-1:0] r_c_target;
  logic [31:0]     r_perf_br;
  logic [31:0]     r_perf_mp;

  logic [IDX_W-1:0]   w_if_idx, w_id_idx;
  logic [TAG_MAX-1:0] w_if_tag, w_id_tag;
  logic               w_if_hit, w_id_hit;
  logic               w_pred_taken;
  logic [XLEN-1:0]    w_pred_target;
  logic               w_eval;
  logic [XLEN-1:0]    w_actual, w_predicted;
  logic               w_redirect;
  logic [CNT_W-1:0]   w_cnt_next;

  assign w_if_idx = IDX_W'(pc_index(XLEN_MAX'(bus.if_pc), IDX_W));
  assign w_if_tag = pc_tag(XLEN_MAX'(bus.if_pc), IDX_W);
  assign w_id_idx = IDX_W'(pc_index(XLEN_MAX'(bus.id_pc), IDX_W));
  assign w_id_tag = pc_tag(XLEN_MAX'(bus.id_pc), IDX_W);

  assign w_if_hit = r_tbl[w_if_idx].valid && (r_tbl[w_if_idx].tag == w_if_tag);
  assign w_id_hit = r_tbl[w_id_idx].valid && (r_tbl[w_id_idx].tag == w_id_tag);

  assign w_pred_taken  = w_if_hit && r_tbl[w_if_idx].cnt[CNT_W-1];
  assign w_pred_target = w_pred_taken ? XLEN'(r_tbl[w_if_idx].target)
                                      : bus.if_pc + XLEN'(4);

  assign w_eval      = bus.id_valid && !bus.id_stall;
  assign w_actual    = (bus.id_is_branch && bus.id_taken) ? bus.id_target
                                                          : bus.id_pc + XLEN'(4);
  assign w_predicted = r_c_taken ? r_c_target : bus.id_pc + XLEN'(4);
  assign w_redirect  = w_eval && (w_actual != w_predicted);

  sat_counter #(.CNT_W(CNT_W)) u_cnt (
    .i_cnt (CNT_W'(r_tbl[w_id_idx].cnt)),
    .i_inc (bus.id_taken),
    .o_cnt (w_cnt_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        r_tbl[IDX_W'(i)].valid  <= 1'b0;
        r_tbl[IDX_W'(i)].tag    <= '0;
        r_tbl[IDX_W'(i)].target <= '0;
        r_tbl[IDX_W'(i)].cnt    <= WN;
      end
    end else if (w_eval) begin
      if (bus.id_is_branch) begin
        if (!w_id_hit) begin
          r_tbl[w_id_idx].valid  <= 1'b1;
          r_tbl[w_id_idx].tag    <= w_id_tag;
          r_tbl[w_id_idx].target <= XLEN_MAX'(bus.id_target);
          r_tbl[w_id_idx].cnt    <= bus.id_taken ? WT : WN;
        end else begin
          r_tbl[w_id_idx].cnt <= CNT_MAX'(w_cnt_next);
          if (bus.id_taken) r_tbl[w_id_idx].target <= XLEN_MAX'(bus.id_target);
        end
      end else if (w_id_hit) begin
        // A non-branch hitting the table means an aliased entry; drop it.
        r_tbl[w_id_idx].valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_c_taken  <= 1'b0;
      r_c_target <= '0;
      r_perf_br  <= '0;
      r_perf_mp  <= '0;
    end else begin
      if (bus.id_flush || w_redirect) begin
        r_c_taken  <= 1'b0;
        r_c_target <= '0;
      end else if (!bus.id_stall) begin
        r_c_taken  <= w_pred_taken;
        r_c_target <= w_pred_target;
      end
      if (w_eval && bus.id_is_branch) r_perf_br <= r_perf_br + 32'd1;
      if (w_redirect)                 r_perf_mp <= r_perf_mp + 32'd1;
    end
  end

  assign bus.if_pred_taken    = w_pred_taken;
  assign bus.if_pred_target   = w_pred_target;
  assign bus.id_redirect      = w_redirect;
  assign bus.id_redirect_pc   = w_actual;
  assign bus.perf_branches    = r_perf_br;
  assign bus.perf_mispredicts = r_perf_mp;
endmodule

// File: tb/tb_bpu.sv
// Bench for bpu: hand-derived directed vector table, then randomized traffic
// checked against a behavioural BTB model.
module tb_bpu;
  localparam int unsigned ENTRIES = 16;
  localparam int unsigned CNT_W   = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bpu_if #(.XLEN(32)) bus ();
  bpu #(.XLEN(32), .ENTRIES(ENTRIES), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    bit          rst, stall, flush, valid, br, tk;
    logic [31:0] if_pc, id_pc, tgt;
    bit          chk;
    bit          e_tk;
    logic [31:0] e_tgt;
    bit          e_rd;
    logic [31:0] e_rpc;
    int unsigned e_br, e_mp;
  } vec_t;

  vec_t vecs[$];
  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  bit          m_valid [ENTRIES];
  int unsigned m_tag   [ENTRIES];
  logic [31:0] m_tgt   [ENTRIES];
  int          m_cnt   [ENTRIES];
  bit          mc_tk;
  logic [31:0] mc_tgt;
  int unsigned m_br, m_mp;

  function automatic vec_t mk(input bit r, s, f, v, b, t,
                              input logic [31:0] ifpc, idpc, tg,
                              input bit c, etk, input logic [31:0] etg,
                              input bit erd, input logic [31:0] erpc,
                              input int unsigned ebr, emp);
    vec_t x;
    x.rst = r; x.stall = s; x.flush = f; x.valid = v; x.br = b; x.tk = t;
    x.if_pc = ifpc; x.id_pc = idpc; x.tgt = tg; x.chk = c;
    x.e_tk = etk; x.e_tgt = etg; x.e_rd = erd; x.e_rpc = erpc;
    x.e_br = ebr; x.e_mp = emp;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  function automatic void model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 1'b0; m_tag[i] = 0; m_tgt[i] = '0; m_cnt[i] = (1 << (CNT_W - 1)) - 1;
    end
    mc_tk = 1'b0; mc_tgt = '0; m_br = 0; m_mp = 0;
  endfunction

  function automatic void lookup(input logic [31:0] pc, output bit tk, output logic [31:0] tg);
    int unsigned idx = (pc / 4) % ENTRIES;
    int unsigned tag = pc / (4 * ENTRIES);
    tk = m_valid[idx] && (m_tag[idx] == tag) && (m_cnt[idx] >= (1 << (CNT_W - 1)));
    tg = tk ? m_tgt[idx] : pc + 32'd4;
  endfunction

  task automatic run(input vec_t v, input bit from_tbl);
    bit          p_tk, eval, rd, hit;
    logic [31:0] p_tg, actual, predicted;
    int unsigned idx, tag;
    rst = v.rst;
    bus.if_pc = v.if_pc; bus.id_stall = v.stall; bus.id_flush = v.flush;
    bus.id_valid = v.valid; bus.id_pc = v.id_pc; bus.id_is_branch = v.br;
    bus.id_taken = v.tk; bus.id_target = v.tgt;
    #4;
    lookup(v.if_pc, p_tk, p_tg);
    eval      = v.valid && !v.stall;
    actual    = (v.br && v.tk) ? v.tgt : v.id_pc + 32'd4;
    predicted = mc_tk ? mc_tgt : v.id_pc + 32'd4;
    rd        = eval && (actual != predicted);
    if (from_tbl) begin
      if (v.chk) begin
        chk("tbl_pred_taken", 32'(bus.if_pred_taken), 32'(v.e_tk));
        chk("tbl_pred_target", bus.if_pred_target, v.e_tgt);
        chk("tbl_redirect", 32'(bus.id_redirect), 32'(v.e_rd));
        if (v.e_rd) chk("tbl_redirect_pc", bus.id_redirect_pc, v.e_rpc);
        chk("tbl_perf_branches", bus.perf_branches, v.e_br);
        chk("tbl_perf_mispredicts", bus.perf_mispredicts, v.e_mp);
      end
    end else begin
      chk("rnd_pred_taken", 32'(bus.if_pred_taken), 32'(p_tk));
      chk("rnd_pred_target", bus.if_pred_target, p_tg);
      chk("rnd_redirect", 32'(bus.id_redirect), 32'(rd));
      if (eval) chk("rnd_redirect_pc", bus.id_redirect_pc, actual);
      chk("rnd_perf_branches", bus.perf_branches, m_br);
      chk("rnd_perf_mispredicts", bus.perf_mispredicts, m_mp);
    end
    if (v.rst) begin
      model_reset();
    end else begin
      idx = (v.id_pc / 4) % ENTRIES;
      tag = v.id_pc / (4 * ENTRIES);
      hit = m_valid[idx] && (m_tag[idx] == tag);
      if (eval && v.br) begin
        if (!hit) begin
          m_valid[idx] = 1'b1; m_tag[idx] = tag; m_tgt[idx] = v.tgt;
          m_cnt[idx] = v.tk ? (1 << (CNT_W - 1)) : (1 << (CNT_W - 1)) - 1;
        end else if (v.tk) begin
          m_cnt[idx] = (m_cnt[idx] + 1 > (1 << CNT_W) - 1) ? (1 << CNT_W) - 1 : m_cnt[idx] + 1;
          m_tgt[idx] = v.tgt;
        end else begin
          m_cnt[idx] = (m_cnt[idx] == 0) ? 0 : m_cnt[idx] - 1;
        end
        m_br++;
      end else if (eval && hit) begin
        m_valid[idx] = 1'b0;
      end
      if (rd) m_mp++;
      if (v.flush || rd) begin mc_tk = 1'b0; mc_tgt = '0; end
      else if (!v.stall) begin mc_tk = p_tk; mc_tgt = p_tg; end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] pcs [8];
    logic [31:0] tgts [4];
    vec_t        r;
    pcs  = '{32'h100, 32'h140, 32'h104, 32'h204, 32'h300, 32'h0, 32'h108, 32'h1100};
    tgts = '{32'h80, 32'h40, 32'h1000, 32'h204};

    //            rst st fl va br tk  if_pc    id_pc    tgt    chk etk  etgt    erd  erpc   br  mp
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 'h100, 'h0,   'h0,  0, 0, 'h0,   0, 'h0,   0,  0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 'h100, 'h0,   'h0,  1, 0, 'h104, 0, 'h0,   0,  0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 1, 'h200, 'h100, 'h80, 1, 0, 'h204, 1, 'h80,  0,  0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 'h100, 'h0,   'h0,  1, 1, 'h80,  0, 'h0,   1,  1));
    vecs.push_back(mk(0, 0, 0, 1, 1, 0, 'h300, 'h100, 'h80, 1, 0, 'h304, 1, 'h104, 1,  1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 'h100, 'h0,   'h0,  1, 0, 'h104, 0, 'h0,   2,  2));
    vecs.push_back(mk(0, 0, 0, 1, 1, 1, 'h0,   'h100, 'h80, 1, 0, 'h4,   1, 'h80,  2,  2));
    vecs.push_back(mk(0, 0, 0, 1, 1, 1, 'h100, 'h100, 'h80, 1, 1, 'h80,  1, 'h80,  3,  3));
    vecs.push_back(mk(0, 0, 0, 1, 1, 1, 'h100, 'h100, 'h80, 1, 1, 'h80,  1, 'h80,  4,  4));
    vecs.push_back(mk(0, 0, 0, 1, 1, 1, 'h100, 'h100, 'h80, 1, 1, 'h80,  1, 'h80,  5,  5));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 'h100, 'h0,   'h0,  1, 1, 'h80,  0, 'h0,   6,  6));
    vecs.push_back(mk(0, 0, 0, 1, 1, 1, 'h140, 'h100, 'h80, 1, 0, 'h144, 0, 'h0,   6,  6));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 'h100, 'h140, 'h0,  1, 1, 'h80,  0, 'h0,   7,  6));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 'h100, 'h100, 'h0,  1, 1, 'h80,  1, 'h104, 7,  6));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 'h100, 'h0,   'h0,  1, 0, 'h104, 0, 'h0,   7,  7));
    vecs.push_back(mk(0, 0, 0, 1, 1, 1, 'h204, 'h204, 'h40, 1, 0, 'h208, 1, 'h40,  7,  7));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 'h204, 'h0,   'h0,  1, 1, 'h40,  0, 'h0,   8,  8));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(0, 1, 0, 1, 1, 0, 'h300, 'h204, 'h40, 1, 0, 'h304, 0, 'h0,   8,  8));
    vecs.push_back(mk(0, 0, 0, 1, 1, 0, 'h300, 'h204, 'h40, 1, 0, 'h304, 1, 'h208, 8,  8));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 'h204, 'h0,   'h0,  1, 0, 'h208, 0, 'h0,   9,  9));
    vecs.push_back(mk(0, 0, 0, 1, 1, 1, 'h204, 'h204, 'h40, 1, 0, 'h208, 1, 'h40,  9,  9));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 'h204, 'h0,   'h0,  1, 1, 'h40,  0, 'h0,  10, 10));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 'h204, 'h0,   'h0,  1, 1, 'h40,  0, 'h0,  10, 10));
    vecs.push_back(mk(0, 0, 0, 1, 1, 1, 'h300, 'h204, 'h40, 1, 0, 'h304, 1, 'h40, 10, 10));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 'h204, 'h0,   'h0,  1, 1, 'h40,  0, 'h0,  11, 11));
    vecs.push_back(mk(0, 0, 1, 1, 1, 0, 'h204, 'h204, 'h40, 1, 1, 'h40,  1, 'h208,11, 11));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 'h204, 'h0,   'h0,  1, 1, 'h40,  0, 'h0,  12, 12));
    vecs.push_back(mk(1, 1, 0, 1, 1, 0, 'h204, 'h204, 'h40, 0, 0, 'h0,   0, 'h0,   0,  0));
    vecs.push_back(mk(0, 1, 0, 1, 1, 0, 'h204, 'h204, 'h40, 1, 0, 'h208, 0, 'h0,   0,  0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 0, 'h204, 'h204, 'h40, 1, 0, 'h208, 0, 'h0,   0,  0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 'h204, 'h0,   'h0,  1, 0, 'h208, 0, 'h0,   1,  0));

    rst = 1'b1;
    bus.if_pc = '0; bus.id_stall = 1'b0; bus.id_flush = 1'b0; bus.id_valid = 1'b0;
    bus.id_pc = '0; bus.id_is_branch = 1'b0; bus.id_taken = 1'b0; bus.id_target = '0;
    model_reset();
    @(posedge clk);
    #1;

    foreach (vecs[i]) run(vecs[i], 1'b1);

    for (int n = 0; n < 600; n++) begin
      r = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      r.rst   = ($urandom_range(0, 99) == 0);
      r.stall = ($urandom_range(0, 4) == 0);
      r.flush = ($urandom_range(0, 9) == 0);
      r.valid = ($urandom_range(0, 4) != 0);
      r.br    = ($urandom_range(0, 9) < 7);
      r.tk    = ($urandom_range(0, 9) < 6);
      r.if_pc = pcs[$urandom_range(0, 7)];
      r.id_pc = pcs[$urandom_range(0, 7)];
      r.tgt   = tgts[$urandom_range(0, 3)];
      run(r, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/bpu.md
# bpu

Parametrised dynamic branch prediction unit for the 5-stage pipeline, replacing static predict-not-taken hazard handling. It performs a same-cycle lookup on the IF-stage PC in a direct-mapped branch target buffer (BTB) with per-entry saturating counters. It carries the prediction into ID, compares it with the resolved outcome, and raises a redirect on mismatch. It trains the table on every resolved control-flow instruction.

## Interface
- XLEN, 32, address/data width.
- ENTRIES, 16, number of BTB entries; power of two, at least 2. IDX_W = log2(ENTRIES); TAG_W = XLEN-2-IDX_W.
- CNT_W, 2, width of each saturating counter, at least 2.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- if_pc  in  XLEN  PC currently being fetched.
- if_pred_taken  out  1  prediction for if_pc.
- if_pred_target  out  XLEN  predicted next PC: the stored target if predicted taken, else if_pc+4.
- id_stall  in  1  ID is held; keep the carried prediction and do not train.
- id_flush  in  1  ID is invalidated next cycle; clear the carried prediction.
- id_valid  in  1  ID holds a real instruction, not a bubble.
- id_pc  in  XLEN  PC of the instruction in ID.
- id_is_branch  in  1  ID instruction is a conditional branch, jal or jalr.
- id_taken  in  1  resolved direction; must be 1 for jal/jalr.
- id_target  in  XLEN  resolved target.
- id_redirect  out  1  mispredict; IF must load id_redirect_pc and the IF instruction must be squashed.
- id_redirect_pc  out  XLEN  correct next PC.
- perf_branches  out  32  count of trained control-flow instructions.
- perf_mispredicts  out  32  count of redirect events.

## Operation
- Index is pc[IDX_W+1:2]; tag is pc[XLEN-1:IDX_W+2].
- Each entry holds: valid, tag, target, and a counter.
- Lookup hit = valid && tag match. if_pred_taken = hit && counter MSB.
- Carried prediction register (taken bit + target) works as follows:
  - Loads the IF prediction each cycle.
  - Holds while id_stall=1.
  - Clears to {0, 0} on rst, id_flush, or id_redirect.
  - Priority: rst > flush/redirect > stall > load.
- ID evaluation happens when id_valid && !id_stall:
  - actual = (id_is_branch && id_taken) ? id_target : id_pc+4.
  - predicted = carried_taken ? carried_target : id_pc+4.
  - id_redirect = (actual != predicted); id_redirect_pc = actual.
  - When the evaluation condition is false, id_redirect = 0.
- Training happens under the same condition:
  - Branch, entry missed: allocate. Set valid and tag. Target = id_target. Counter = WT (2^(CNT_W-1)) if taken, else WN (2^(CNT_W-1)-1).
  - Branch, entry hit: counter saturating-increments if taken, saturating-decrements if not taken. Target is overwritten only when taken.
  - Non-branch that hits (alias): clear the valid bit.
- Perf counters:
  - perf_branches increments on every training of a branch.
  - perf_mispredicts increments on every id_redirect.
  - Both wrap at 2^32.
- Reset clears all valid bits, sets all counters to WN, and zeroes both perf counters. id_redirect=0 and if_pred_taken=0 in the cycle after reset.

## Timing
- Lookup is combinational, 0 cycles: if_pc to if_pred_*.
- Training write takes effect at the next edge and is visible to lookup 1 cycle later. A same-cycle read and write to the same index returns the old entry; there is no bypass.
- Redirect is combinational from the ID inputs and the carried register, so the pipeline flushes the IF instruction in the same cycle.
- A flush and a valid evaluation in the same cycle are legal. The redirect is still produced and training still occurs; flush only clears the carried register.
- Counter saturation at 0 and at 2^CNT_W-1 must hold without wrap.
- Asserting rst mid-stall discards the stall and all table state.

## Structure
- Package bpu_pkg holds:
  - CNT_WT / CNT_WN derivation functions.
  - The entry struct typedef {valid, tag, target, cnt}.
  - Index/tag extraction functions parametrised on XLEN/IDX_W.
- Sub-module sat_counter(CNT_W) provides the next-value logic: increment or decrement with saturation.
- Table storage is a register array with synchronous reset, because valid bits must be cleared in one cycle.

## Test plan
- Reset, then if_pc=0x100 → if_pred_taken=0, if_pred_target=0x104; perf counters 0.
- Taken branch at ID, id_pc=0x100, target 0x80, no prior entry:
  - id_redirect=1, id_redirect_pc=0x80.
  - Next cycle, if_pc=0x100 → taken, target 0x80 (counter WT).
- Same branch predicted taken, then resolved not-taken:
  - Redirect to 0x104; counter goes to WN; the following lookup predicts not-taken.
  - After 3 consecutive taken resolutions, the counter saturates at 3 and a 4th does not wrap.
- ENTRIES=16 alias: branch at 0x100 trained, then a non-branch at 0x140 (same index, different tag) in ID:
  - 0x140 lookup misses, so no redirect.
  - Non-branch at 0x100 predicted taken → redirect to 0x104 and entry invalidated.
- Carried-register handling:
  - id_stall held 3 cycles with a mispredicted branch in ID → no redirect and no training until the stall drops, then exactly one redirect and perf_mispredicts+1.
  - id_flush → carried register cleared.
